mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Target-side end of the CPU byte-wide memory bus: decodes the address, data-out and write-strobe driven by the CPU and returns read bytes one cycle later.
- Provides the 128KB RAM and the memory-mapped I/O at 0x30000/0x30004 (UART rx/tx, cycle counter, program stop).
- Generates io_buffer_full back to the CPU.
- Sits between the cpu top-level bus pins and the UART/host interface in simulation and FPGA top-levels.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (2^17 = 128KB).
TX_FIFO_DEPTH, 8, UART tx FIFO entries; power of two, >= 4.
FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN.

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous, active-low reset
cpu_a  input  32  bus address from CPU; only bits 17:0 decoded
cpu_wr  input  1  1 = write cycle, 0 = read cycle
cpu_dout  input  8  write data from CPU
cpu_din  output  8  read data to CPU, registered
io_buffer_full  output  1  tx FIFO nearly full
rx_valid  input  1  input byte available
rx_data  input  8  input byte
rx_ready  output  1  one-cycle pulse: rx byte consumed
tx_valid  output  1  tx FIFO non-empty
tx_data  output  8  tx FIFO head byte
tx_ready  input  1  sink accepts head this cycle
program_stop  output  1  sticky, set by a write to 0x30004
tx_overflow  output  1  sticky, a tx byte was dropped

Behaviour:
- Reset (rst_in low, async): cpu_din=0, rx_ready=0, FIFO empty (tx_valid=0, tx_data=0), io_buffer_full=0, program_stop=0, tx_overflow=0, cycle counter=0, snapshot=0. RAM contents not reset. Reset mid-operation discards FIFO contents and any pending read.
- Decode: io_sel = cpu_a[17:16]==2'b11; ram_sel = cpu_a[17]==0; cpu_a[17:16]==2'b10 is unmapped.
- Every cycle is a bus cycle; no idle strobe. Read cycle = cpu_wr low.
- Read latency exactly 1: a read presented in cycle N drives cpu_din during cycle N+1.
- Write cycles leave cpu_din holding its previous value.
- RAM: write stores cpu_dout at cpu_a[16:0] at the clock edge. Read returns the stored byte. Write in N followed by read of the same address in N+1 returns the new byte.
- Unmapped or undefined I/O (a[17:16]==10, or I/O offset not 0x0 or 0x4..0x7): reads return 0x00; writes ignored.
- 0x30000 read: if rx_valid, the next cpu_din = rx_data and rx_ready pulses high in cycle N. Otherwise cpu_din = 0x00 and rx_ready stays low.
- Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF -> 0.
- 0x30004 read loads a snapshot of the counter and returns byte 0 (bits 7:0) of the counter value in cycle N.
- 0x30005/6/7 reads return snapshot bytes 1/2/3, so a little-endian 4-byte load is coherent. These reads never reload the snapshot.
- 0x30000 write: cpu_dout==0x00 is ignored. Otherwise the byte is pushed if the FIFO has space, or the FIFO pops this cycle.
- If the FIFO is full with no pop, the byte is dropped and tx_overflow is set.
- 0x30004 write: program_stop set. 0x00 is pushed into the FIFO; the zero filter is bypassed and the same full/overflow rule applies.
- Once program_stop=1, all further I/O writes are ignored. RAM and reads continue.
- FIFO: tx_data = head. Pop when tx_valid && tx_ready.
- Simultaneous push and pop keeps the count unchanged, including when full or when count==1.
- Pointers wrap modulo TX_FIFO_DEPTH; count range 0..TX_FIFO_DEPTH.
- io_buffer_full = (TX_FIFO_DEPTH - count) <= FULL_MARGIN, decoded from the count register. The margin absorbs CPU store-pipeline lag.

Test Plan:
- Reset then write 0xA5 to 0x00010 in cycle 1, read 0x00010 in cycle 2 -> cpu_din=0xA5 in cycle 3. A write in cycle 3 keeps cpu_din=0xA5 in cycle 4.
- Read 0x1FFFF after writing 0x3C there -> 0x3C. Read 0x20000 -> 0x00. Write 0x77 to 0x20000 -> RAM address 0x00000 unchanged.
- rx_valid=1, rx_data=0x41, read 0x30000 -> rx_ready pulse in cycle N, cpu_din=0x41 in N+1. With rx_valid=0 -> cpu_din=0x00 and no rx_ready pulse.
- Hold tx_ready=0 and write 0x31..0x38 to 0x30000 (depth 8) -> io_buffer_full rises after the 6th push. 9th write dropped, tx_overflow=1. Write 0x00 -> no push. Release tx_ready -> 0x31..0x38 drained in order.
- Read 0x30004..0x30007 in consecutive cycles with counter at 0x000000FF at the first read -> bytes 0xFF,0x00,0x00,0x00. Reads of 0x30005..0x30007 never reload the snapshot.
- Write 0x30004 -> program_stop=1 and 0x00 appears on tx_data. A later write of 0x42 to 0x30000 is ignored. Assert rst_in low mid-drain -> FIFO empty and all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus: address, direction, write data, read data, tx backpressure.
// No latency of its own; it only bundles the wires between CPU and responder.
// io_buffer_full is the only backpressure on this bus and is advisory to the CPU.
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (output cpu_a, cpu_wr, cpu_dout, input cpu_din, io_buffer_full);
  modport slave  (input cpu_a, cpu_wr, cpu_dout, output cpu_din, io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: 128KB RAM, UART rx/tx, cycle counter and program stop behind the CPU bus.
// Read data returns exactly one cycle after the read; writes take effect at the clock edge.
// tx FIFO raises io_buffer_full early by FULL_MARGIN entries; bytes arriving when it is full are dropped.
module mem_io_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              program_stop,
  output logic              tx_overflow
);
  localparam int OFF_W = ADDR_WIDTH - 1;
  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Address decode: bit 17 clear selects RAM, bits 17:16 == 11 select I/O, 10 is a hole.
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [OFF_W-1:0]      io_off;
  logic                  ram_sel, io_sel, rd, off_rx, off_tick;
  logic                  unused_addr_hi;

  assign ram_addr       = bus.cpu_a[ADDR_WIDTH-1:0];
  assign io_off         = bus.cpu_a[OFF_W-1:0];
  assign ram_sel        = ~bus.cpu_a[ADDR_WIDTH];
  assign io_sel         = bus.cpu_a[ADDR_WIDTH] & bus.cpu_a[ADDR_WIDTH-1];
  assign rd             = ~bus.cpu_wr;
  assign off_rx         = (io_off == OFF_W'(0));
  assign off_tick       = (io_off == OFF_W'(4));
  assign unused_addr_hi = ^bus.cpu_a[31:ADDR_WIDTH+1];

  logic [7:0]  din_q, din_next;
  logic [31:0] cycle_cnt, snap;
  logic        stop_q, ovf_q;

  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             io_wr, stop_wr, push_req, push, pop, drop, fifo_full;
  logic [7:0]       push_dat;

  logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];

  // RAM array: synchronous byte write, contents survive reset.
  always_ff @(posedge clk_in) begin
    if (bus.cpu_wr && ram_sel)
      ram[ram_addr] <= bus.cpu_dout;
  end

  // Read-data select; write cycles hold the last read byte.
  always_comb begin
    din_next = din_q;
    if (rd) begin
      if (ram_sel) begin
        din_next = ram[ram_addr];
      end else if (io_sel) begin
        case (io_off)
          OFF_W'(0): din_next = rx_valid ? rx_data : 8'h00;
          OFF_W'(4): din_next = cycle_cnt[7:0];
          OFF_W'(5): din_next = snap[15:8];
          OFF_W'(6): din_next = snap[23:16];
          OFF_W'(7): din_next = snap[31:24];
          default:   din_next = 8'h00;
        endcase
      end else begin
        din_next = 8'h00;
      end
    end
  end

  // rx byte is consumed in the same cycle the CPU reads the rx register.
  assign rx_ready = rst_in & rd & io_sel & off_rx & rx_valid;

  // I/O writes are frozen once the program has stopped; the stop byte bypasses the zero filter.
  assign io_wr     = bus.cpu_wr & io_sel & ~stop_q;
  assign stop_wr   = io_wr & off_tick;
  assign push_req  = (io_wr & off_rx & (bus.cpu_dout != 8'h00)) | stop_wr;
  assign push_dat  = stop_wr ? 8'h00 : bus.cpu_dout;
  assign pop       = tx_valid & tx_ready;
  assign fifo_full = (count == CNT_W'(TX_FIFO_DEPTH));
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;

  // Bus-side registers: read data, free-running counter, snapshot and sticky flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_q     <= 8'h00;
      cycle_cnt <= 32'h0;
      snap      <= 32'h0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      din_q     <= din_next;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd && io_sel && off_tick) snap <= cycle_cnt;
      if (stop_wr) stop_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage: written only on an accepted push, never reset.
  always_ff @(posedge clk_in) begin
    if (push)
      fifo_mem[wr_ptr] <= push_dat;
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign tx_valid           = (count != '0);
  assign tx_data            = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign bus.io_buffer_full = (CNT_W'(TX_FIFO_DEPTH) - count) <= CNT_W'(FULL_MARGIN);
  assign bus.cpu_din        = din_q;
  assign program_stop       = stop_q;
  assign tx_overflow        = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboarded bench for mem_io_responder: a queue/array reference model predicts every output.
// Read data expectations are queued with their due cycle and popped by an independent monitor.
// tx side is checked every cycle against a queue model of the FIFO contents.
module tb_mem_io_responder;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, program_stop, tx_overflow;
  logic [7:0] rx_data, tx_data;

  mem_io_responder_if bus ();

  mem_io_responder #(.ADDR_WIDTH(17), .TX_FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in(clk), .rst_in(rst_in), .bus(bus),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [7:0] val; } rd_exp_t;
  rd_exp_t rdq[$];

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  fifo_m[$];
  logic [31:0] cnt_m, snap_m;
  logic [7:0]  din_m;
  bit          stop_m, ovf_m;

  // Expected combinational/registered outputs for the current cycle
  logic       exp_rx_ready, exp_full, exp_ovf, exp_stop, exp_tx_valid;
  logic [7:0] exp_tx_data;

  int unsigned cyc = 0;
  bit          check_en = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compares every output against the model, pops read data when it falls due.
  always @(negedge clk) begin
    if (check_en) begin
      check("rx_ready", rx_ready, exp_rx_ready);
      check("io_buffer_full", bus.io_buffer_full, exp_full);
      check("tx_overflow", tx_overflow, exp_ovf);
      check("program_stop", program_stop, exp_stop);
      check("tx_valid", tx_valid, exp_tx_valid);
      check("tx_data", tx_data, exp_tx_data);
      while (rdq.size() > 0 && rdq[0].due < cyc) begin
        failures++;
        $display("FAIL cpu_din_missed due=%0d cyc=%0d", rdq[0].due, cyc);
        void'(rdq.pop_front());
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        rd_exp_t e;
        e = rdq.pop_front();
        check("cpu_din", bus.cpu_din, e.val);
      end
    end
  end

  task automatic set_cur_expect();
    exp_full     = (DEPTH - fifo_m.size()) <= MARGIN;
    exp_ovf      = ovf_m;
    exp_stop     = stop_m;
    exp_tx_valid = fifo_m.size() > 0;
    exp_tx_data  = (fifo_m.size() > 0) ? fifo_m[0] : 8'h00;
  endtask

  task automatic do_reset();
    cyc++;
    rst_in = 1'b0;
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h10; rx_valid = 1'b0; tx_ready = 1'b0;
    fifo_m.delete();
    din_m = 8'h00; cnt_m = 0; snap_m = 0; stop_m = 0; ovf_m = 0;
    rdq.delete();
    rdq.push_back('{cyc, 8'h00});
    rdq.push_back('{cyc + 1, 8'h00});
    exp_rx_ready = 1'b0;
    set_cur_expect();
    check_en = 1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_in = 1'b1;
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                           input logic rxv, input logic [7:0] rxd, input logic txr);
    logic [1:0]  region;
    logic [15:0] off;
    logic [7:0]  nxt, pv;
    bit          push_req;
    cyc++;
    bus.cpu_a = a; bus.cpu_wr = wr; bus.cpu_dout = d;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    region = a[17:16];
    off    = a[15:0];
    exp_rx_ready = !wr && region == 2'b11 && off == 16'h0 && rxv;
    set_cur_expect();
    nxt = din_m;
    if (!wr) begin
      if (!a[17]) nxt = ram_m[int'(a[16:0])];
      else if (region == 2'b11) begin
        case (off)
          16'h0:   nxt = rxv ? rxd : 8'h00;
          16'h4:   nxt = cnt_m[7:0];
          16'h5:   nxt = snap_m[15:8];
          16'h6:   nxt = snap_m[23:16];
          16'h7:   nxt = snap_m[31:24];
          default: nxt = 8'h00;
        endcase
      end else nxt = 8'h00;
    end
    rdq.push_back('{cyc + 1, nxt});
    @(negedge clk); #1;
    // Advance the model across the closing clock edge
    din_m = nxt;
    if (!wr && region == 2'b11 && off == 16'h4) snap_m = cnt_m;
    if (txr && fifo_m.size() > 0) void'(fifo_m.pop_front());
    push_req = 0; pv = 8'h00;
    if (wr && region == 2'b11 && !stop_m) begin
      if (off == 16'h0 && d != 8'h00) begin push_req = 1; pv = d; end
      else if (off == 16'h4) begin push_req = 1; pv = 8'h00; stop_m = 1; end
    end
    if (wr && !a[17]) ram_m[int'(a[16:0])] = d;
    if (push_req) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(pv);
      else ovf_m = 1;
    end
    cnt_m = cnt_m + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic wr_cyc(input logic [31:0] a, input logic [7:0] d, input logic txr);
    bus_cycle(a, 1'b1, d, 1'b0, 8'h00, txr);
  endtask

  task automatic rd_cyc(input logic [31:0] a, input logic txr);
    bus_cycle(a, 1'b0, 8'h00, 1'b0, 8'h00, txr);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [31:0] pool  [6] = '{32'h00010, 32'h1FFFF, 32'h00000, 32'h00123, 32'h0ABCD, 32'h10000};
  logic [15:0] ioffs [7] = '{16'h0, 16'h4, 16'h5, 16'h6, 16'h7, 16'h1, 16'h8};
  logic [15:0] woffs [4] = '{16'h1, 16'h2, 16'h3, 16'h8};

  initial begin
    logic [31:0] a, hi;
    logic        wr;
    logic [7:0]  d;
    int unsigned r;
    rst_in = 1'b0; bus.cpu_a = 32'h0; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    do_reset();

    // RAM write, read-back, hold on write
    wr_cyc(32'h10, 8'hA5, 1'b1);
    rd_cyc(32'h10, 1'b1);
    wr_cyc(32'h11, 8'h5A, 1'b1);
    rd_cyc(32'h10, 1'b1);
    // Top of RAM, unmapped hole
    wr_cyc(32'h1FFFF, 8'h3C, 1'b1);
    rd_cyc(32'h1FFFF, 1'b1);
    rd_cyc(32'h20000, 1'b1);
    wr_cyc(32'h00000, 8'h11, 1'b1);
    wr_cyc(32'h20000, 8'h77, 1'b1);
    rd_cyc(32'h00000, 1'b1);
    // rx register with and without a byte waiting
    bus_cycle(32'h30000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
    bus_cycle(32'h30000, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1);
    rd_cyc(32'h10, 1'b1);

    // Fill tx FIFO with sink stalled, overflow, zero filter, then drain
    for (int i = 0; i < 9; i++) wr_cyc(32'h30000, 8'(8'h31 + i), 1'b0);
    wr_cyc(32'h30000, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) rd_cyc(32'h10, 1'b1);

    // Counter snapshot coherence
    do_reset();
    while (cnt_m != 32'hFF) rd_cyc(32'h10, 1'b1);
    for (int i = 4; i < 8; i++) rd_cyc(32'h30000 | i, 1'b1);
    rd_cyc(32'h10, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 6; i++) wr_cyc(pool[i], 8'($urandom), 1'b1);
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom_range(0, 9);
      hi = $urandom() & 32'hFFFC_0000;
      d  = 8'($urandom);
      wr = 1'($urandom_range(0, 1));
      case (r)
        0, 1, 2, 3: a = hi | pool[$urandom_range(0, 5)];
        4:          a = hi | 32'h20000 | ($urandom() & 32'hFFFF);
        5, 6, 7: begin a = hi | 32'h30000 | 32'(ioffs[$urandom_range(0, 6)]); wr = 1'b0; end
        default: begin
          a  = hi | 32'h30000 | (($urandom_range(0, 3) == 0) ? 32'(woffs[$urandom_range(0, 3)]) : 32'h0);
          wr = 1'b1;
          if ($urandom_range(0, 3) == 0) d = 8'h00;
        end
      endcase
      bus_cycle(a, wr, d, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Program stop, frozen I/O writes, reset in the middle of a drain
    for (int i = 0; i < 10; i++) rd_cyc(32'h10, 1'b1);
    wr_cyc(32'h30000, 8'h55, 1'b0);
    wr_cyc(32'h30000, 8'h66, 1'b0);
    wr_cyc(32'h30004, 8'hEE, 1'b0);
    wr_cyc(32'h30000, 8'h42, 1'b0);
    rd_cyc(32'h10, 1'b1);
    rd_cyc(32'h10, 1'b1);
    rd_cyc(32'h10, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) rd_cyc(32'h10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
